// File: rtl/smc_frame_loader_if.sv
// Handshake and parallel-frame bundle between the upstream beat source, the
// frame loader and the SMC inputs.
interface smc_frame_loader_if #(parameter int CNT_W = 8);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       W_in, V_GS_in, V_DS_in;
    logic [1:0]       mode_in;
    logic             out_ready;
    logic             out_valid;
    logic [2:0]       W_0, W_1, W_2, W_3, W_4, W_5;
    logic [2:0]       V_GS_0, V_GS_1, V_GS_2, V_GS_3, V_GS_4, V_GS_5;
    logic [2:0]       V_DS_0, V_DS_1, V_DS_2, V_DS_3, V_DS_4, V_DS_5;
    logic [1:0]       mode;
    logic             err;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output in_valid, W_in, V_GS_in, V_DS_in, mode_in, out_ready,
        input  in_ready, out_valid, mode, err, frame_cnt,
        input  W_0, W_1, W_2, W_3, W_4, W_5,
        input  V_GS_0, V_GS_1, V_GS_2, V_GS_3, V_GS_4, V_GS_5,
        input  V_DS_0, V_DS_1, V_DS_2, V_DS_3, V_DS_4, V_DS_5
    );
    modport slave (
        input  in_valid, W_in, V_GS_in, V_DS_in, mode_in, out_ready,
        output in_ready, out_valid, mode, err, frame_cnt,
        output W_0, W_1, W_2, W_3, W_4, W_5,
        output V_GS_0, V_GS_1, V_GS_2, V_GS_3, V_GS_4, V_GS_5,
        output V_DS_0, V_DS_1, V_DS_2, V_DS_3, V_DS_4, V_DS_5
    );
endinterface

// File: rtl/smc_frame_loader.sv
// Gathers six (W, V_GS, V_DS) beats into one registered SMC frame, holds it
// until downstream takes it, and drops partial frames that stall too long.
module smc_frame_loader #(
    parameter int GAP_MAX = 4,
    parameter int CNT_W   = 8
) (
    input logic              clk,
    input logic              rst_n,
    smc_frame_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    // gap only needs to count up to GAP_MAX-1: the next idle cycle aborts
    localparam int GW = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
    localparam logic [GW-1:0] GAP_LIM = GW'((GAP_MAX > 0) ? GAP_MAX - 1 : 0);

    state_t           state, nxt;
    logic [2:0]       slot;
    logic [GW-1:0]    gap;
    logic [5:0][2:0]  w_q, vgs_q, vds_q;
    logic [1:0]       mode_q;
    logic             ov_q, err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             beat, last, abort, handoff;

    assign beat    = bus.in_valid & bus.in_ready;
    assign last    = (state == LOAD) && beat && (slot == 3'd5);
    assign abort   = (GAP_MAX != 0) && (state == LOAD) && !beat && (gap == GAP_LIM);
    assign handoff = (state == HOLD) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (beat) nxt = LOAD;
            LOAD:    if (abort) nxt = IDLE; else if (last) nxt = HOLD;
            HOLD:    if (handoff) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state != HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot   <= '0;
            gap    <= '0;
            w_q    <= '0;
            vgs_q  <= '0;
            vds_q  <= '0;
            mode_q <= '0;
            ov_q   <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            err_q <= abort;
            ov_q  <= (nxt == HOLD);
            if (abort) begin
                slot   <= '0;
                gap    <= '0;
                w_q    <= '0;
                vgs_q  <= '0;
                vds_q  <= '0;
                mode_q <= '0;
            end else if (beat) begin
                w_q[slot]   <= bus.W_in;
                vgs_q[slot] <= bus.V_GS_in;
                vds_q[slot] <= bus.V_DS_in;
                if (state == IDLE) mode_q <= bus.mode_in;
                slot <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
                gap  <= '0;
            end else if (state == LOAD && GAP_MAX != 0) begin
                gap <= gap + GW'(1);
            end
            if (handoff) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.err       = err_q;
    assign bus.mode      = mode_q;
    assign bus.frame_cnt = cnt_q;
    assign {bus.W_5, bus.W_4, bus.W_3, bus.W_2, bus.W_1, bus.W_0} = w_q;
    assign {bus.V_GS_5, bus.V_GS_4, bus.V_GS_3, bus.V_GS_2, bus.V_GS_1, bus.V_GS_0} = vgs_q;
    assign {bus.V_DS_5, bus.V_DS_4, bus.V_DS_3, bus.V_DS_2, bus.V_DS_1, bus.V_DS_0} = vds_q;
endmodule

// File: tb/tb_smc_frame_loader.sv
// Directed bench for smc_frame_loader: vector table for a clean frame plus
// hand-written sequences for gaps, abort, backpressure, wrap and reset.
module tb_smc_frame_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    smc_frame_loader_if #(.CNT_W(8)) bus ();
    smc_frame_loader #(.GAP_MAX(4), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;

    always @(negedge clk) if (bus.err === 1'b1) err_cnt++;

    typedef struct {
        logic       iv;
        logic [2:0] w, vgs, vds;
        logic [1:0] md;
        logic       ordy;
        logic       e_ov, e_ir, e_err;
        logic [7:0] e_cnt;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [2:0] w, input logic [2:0] vgs,
                         input logic [2:0] vds, input logic [1:0] md);
        bus.in_valid = iv;
        bus.W_in     = w;
        bus.V_GS_in  = vgs;
        bus.V_DS_in  = vds;
        bus.mode_in  = md;
    endtask

    task automatic beat(input logic [2:0] w, input logic [2:0] vgs,
                        input logic [2:0] vds, input logic [1:0] md);
        drive(1'b1, w, vgs, vds, md);
        step();
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [2:0] fw(input int k);
        case (k)
            0: return bus.W_0;  1: return bus.W_1;  2: return bus.W_2;
            3: return bus.W_3;  4: return bus.W_4;  default: return bus.W_5;
        endcase
    endfunction
    function automatic logic [2:0] fg(input int k);
        case (k)
            0: return bus.V_GS_0;  1: return bus.V_GS_1;  2: return bus.V_GS_2;
            3: return bus.V_GS_3;  4: return bus.V_GS_4;  default: return bus.V_GS_5;
        endcase
    endfunction
    function automatic logic [2:0] fd(input int k);
        case (k)
            0: return bus.V_DS_0;  1: return bus.V_DS_1;  2: return bus.V_DS_2;
            3: return bus.V_DS_3;  4: return bus.V_DS_4;  default: return bus.V_DS_5;
        endcase
    endfunction

    // Slot k of a frame tagged "off": W=k+off, V_GS=7-k, V_DS=k+off+3 (mod 8).
    task automatic load_frame(input int off, input logic [1:0] md, input int gaps);
        for (int k = 0; k < 6; k++) begin
            beat(3'((k + off) & 7), 3'(7 - k), 3'((k + off + 3) & 7), (k == 0) ? md : ~md);
            if (k < 5) repeat (gaps) step();
        end
    endtask

    task automatic chk_frame(input string nm, input int off, input logic [1:0] md);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("%s W_%0d", nm, k),    32'(fw(k)), 32'((k + off) & 7));
            chk($sformatf("%s V_GS_%0d", nm, k), 32'(fg(k)), 32'(7 - k));
            chk($sformatf("%s V_DS_%0d", nm, k), 32'(fd(k)), 32'((k + off + 3) & 7));
        end
        chk({nm, " mode"}, 32'(bus.mode), 32'(md));
    endtask

    initial begin
        vec_t tv[7];
        int   e0;

        drive(1'b0, 3'd0, 3'd0, 3'd0, 2'd0);
        bus.out_ready = 1'b0;

        // 1: reset, then async reset mid-clock after a beat
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        beat(3'd5, 3'd5, 3'd5, 2'd3);
        chk("pre-rst W_0", 32'(bus.W_0), 32'd5);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst W_0", 32'(bus.W_0), 32'd0);
        chk("async rst mode", 32'(bus.mode), 32'd0);
        chk("async rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("async rst frame_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("async rst err", 32'(bus.err), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // 2: back-to-back frame, mode_in changes on beat 2 and must be ignored
        tv[0] = '{1'b1, 3'd1, 3'd2, 3'd3, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        tv[1] = '{1'b1, 3'd2, 3'd2, 3'd3, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        tv[2] = '{1'b1, 3'd3, 3'd2, 3'd3, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        tv[3] = '{1'b1, 3'd4, 3'd2, 3'd3, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        tv[4] = '{1'b1, 3'd5, 3'd2, 3'd3, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        tv[5] = '{1'b1, 3'd6, 3'd2, 3'd3, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tv[6] = '{1'b0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
        for (int i = 0; i < 7; i++) begin
            drive(tv[i].iv, tv[i].w, tv[i].vgs, tv[i].vds, tv[i].md);
            bus.out_ready = tv[i].ordy;
            step();
            chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(tv[i].e_ov));
            chk($sformatf("vec%0d in_ready", i),  32'(bus.in_ready),  32'(tv[i].e_ir));
            chk($sformatf("vec%0d err", i),       32'(bus.err),       32'(tv[i].e_err));
            chk($sformatf("vec%0d frame_cnt", i), 32'(bus.frame_cnt), 32'(tv[i].e_cnt));
        end
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("b2b W_%0d", k),    32'(fw(k)), 32'(k + 1));
            chk($sformatf("b2b V_GS_%0d", k), 32'(fg(k)), 32'd2);
            chk($sformatf("b2b V_DS_%0d", k), 32'(fd(k)), 32'd3);
        end
        chk("b2b mode", 32'(bus.mode), 32'd2);

        // 3: three idle cycles between beats stay under the timeout
        bus.out_ready = 1'b0;
        e0 = err_cnt;
        load_frame(2, 2'd1, 3);
        chk("gapped out_valid", 32'(bus.out_valid), 32'd1);
        chk_frame("gapped", 2, 2'd1);
        chk("gapped no err", 32'(err_cnt), 32'(e0));
        bus.out_ready = 1'b1;
        step();
        chk("gapped handoff", 32'(bus.out_valid), 32'd0);
        chk("gapped frame_cnt", 32'(bus.frame_cnt), 32'd2);

        // 4: abort after 3 beats and 4 idle cycles
        for (int k = 0; k < 3; k++) beat(3'(k + 1), 3'd4, 3'd4, 2'd3);
        repeat (3) step();
        chk("abort err early", 32'(bus.err), 32'd0);
        step();
        chk("abort err", 32'(bus.err), 32'd1);
        chk("abort W_0", 32'(bus.W_0), 32'd0);
        chk("abort W_2", 32'(bus.W_2), 32'd0);
        chk("abort V_GS_1", 32'(bus.V_GS_1), 32'd0);
        chk("abort mode", 32'(bus.mode), 32'd0);
        chk("abort in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("abort err pulse", 32'(bus.err), 32'd0);
        bus.out_ready = 1'b0;
        load_frame(4, 2'd2, 0);
        chk("post-abort out_valid", 32'(bus.out_valid), 32'd1);
        chk_frame("post-abort", 4, 2'd2);
        bus.out_ready = 1'b1;
        step();
        chk("post-abort frame_cnt", 32'(bus.frame_cnt), 32'd3);

        // 5: backpressure in HOLD while upstream keeps offering W=7
        bus.out_ready = 1'b0;
        load_frame(1, 2'd1, 0);
        drive(1'b1, 3'd7, 3'd7, 3'd7, 2'd3);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("bp%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp%0d in_ready", i),  32'(bus.in_ready),  32'd0);
            chk($sformatf("bp%0d W_0", i),       32'(bus.W_0),       32'd1);
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("bp release out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp release frame_cnt", 32'(bus.frame_cnt), 32'd4);
        chk_frame("bp retained", 1, 2'd1);

        // 6: wrap to 0 after 256 frames, then reset mid-frame
        for (int f = 0; f < 251; f++) begin
            load_frame(f & 7, 2'(f & 3), 0);
            step();
        end
        chk("cnt 255", 32'(bus.frame_cnt), 32'd255);
        load_frame(5, 2'd0, 0);
        step();
        chk("cnt wrap", 32'(bus.frame_cnt), 32'd0);
        e0 = err_cnt;
        for (int k = 0; k < 4; k++) beat(3'd7, 3'd7, 3'd7, 2'd3);
        #3 rst_n = 1'b0;
        #1;
        chk("midframe rst W_0", 32'(bus.W_0), 32'd0);
        chk("midframe rst out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) step();
        chk("midframe rst no err", 32'(err_cnt), 32'(e0));
        bus.out_ready = 1'b0;
        load_frame(6, 2'd2, 0);
        chk("after rst out_valid", 32'(bus.out_valid), 32'd1);
        chk_frame("after rst", 6, 2'd2);
        bus.out_ready = 1'b1;
        step();
        chk("after rst frame_cnt", 32'(bus.frame_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
